// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the buffered UART transmitter.
//   tx_state_t       serializer FSM states (PARITY exists only when
//                    UART_TX_PARITY_EN is defined)
//   UART_FRAME_BITS  line bits per frame: 10 (start+8 data+stop) or
//                    11 with the even-parity bit
//   clocks_per_baud  clk cycles each line bit is held
// Configuration macro: UART_TX_PARITY_EN (undefined by default).
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int UART_FRAME_BITS = 11;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int UART_FRAME_BITS = 10;
`endif

  // Integer division: any fractional remainder of the ratio is dropped.
  function automatic int clocks_per_baud(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count-based full/empty.
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push, din    write din when push && !full
//   pop, dout    dout shows the head entry; pop && !empty removes it
//   full, empty  status derived from count
//   count        occupied entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed from a byte FIFO.
//   clk, rst       clock, synchronous active-high reset
//   data_in        byte to transmit
//   data_in_valid  producer offers data_in
//   data_in_ready  FIFO has room (!full)
//   serial_out     UART line, idle high, registered
//   busy           frame in progress or FIFO non-empty
//   fifo_count     occupied FIFO entries
// Handshake: a byte is taken on a rising edge where data_in_valid and
// data_in_ready are both high. data_in_ready depends only on FIFO state,
// never on data_in_valid; valid while not ready is simply ignored.
// Configuration macro: UART_TX_PARITY_EN adds an even-parity bit after
// the data bits (11-bit frame instead of 10).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 10_000_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB   = clocks_per_baud(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       data_q;
  logic             baud_done;
  logic             line_c;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_in_valid),
    .pop   (fifo_pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign data_in_ready = !fifo_full;
  assign busy          = (state != IDLE) || (fifo_count != '0);
  assign baud_done     = (baud_cnt == CNT_LAST);

  // A byte leaves the FIFO when idle, or at the end of a stop bit so the
  // next start bit follows without an idle gap.
  assign fifo_pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));

  // Line level belonging to the current state; serial_out registers it,
  // so the line lags the state by one cycle.
  always_comb begin
    line_c = 1'b1;
    case (state)
      IDLE:   line_c = 1'b1;
      START:  line_c = 1'b0;
      DATA:   line_c = data_q[bit_idx];
`ifdef UART_TX_PARITY_EN
      PARITY: line_c = ^data_q;
`endif
      STOP:   line_c = 1'b1;
      default: line_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      data_q     <= '0;
      serial_out <= 1'b1;
    end else begin
      serial_out <= line_c;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!fifo_empty) begin
            data_q <= fifo_dout;
            state  <= START;
          end
        end

        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              data_q <= fifo_dout;
              state  <= START;
            end else begin
              state  <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 10_000_000, meaning serial bit rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning byte entries buffered (power of two, at least 2).
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port data_in, input, 8, byte to transmit.
REQ-007 SHALL have port data_in_valid, input, 1, producer offers data_in.
REQ-008 SHALL have port data_in_ready, output, 1, FIFO can accept a byte.
REQ-009 SHALL have port serial_out, output, 1, UART line, idle high, registered.
REQ-010 SHALL have port busy, output, 1, frame in progress or FIFO non-empty.
REQ-011 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, occupied entries.

Function
REQ-012 SHALL derive CLOCKS_PER_BAUD = CLOCK_FREQ / BAUD_RATE (integer division); each line bit is held exactly CLOCKS_PER_BAUD cycles.
REQ-013 SHALL push data_in on a rising edge where data_in_valid && data_in_ready; data_in_ready = !full, combinational from FIFO state only, never from data_in_valid.
REQ-014 SHALL ignore data_in_valid while data_in_ready is low; no overwrite, no drop of stored bytes.
REQ-015 SHALL use FSM states IDLE, START, DATA, STOP (plus PARITY per REQ-025).
REQ-016 IDLE: serial_out=1; if FIFO non-empty, pop head and go to START on the same edge.
REQ-017 START: serial_out=0 for one baud period, then DATA with bit index 0.
REQ-018 DATA: serial_out = byte[index], LSB first; after the baud period of index 7 go to STOP (or PARITY).
REQ-019 STOP: serial_out=1 for one baud period; at its end, if FIFO non-empty pop and go directly to START (no idle gap), else IDLE.
REQ-020 Latency: byte pushed into empty FIFO at edge N while IDLE -> popped at edge N+1, serial_out low from edge N+2; one frame = 10*CLOCKS_PER_BAUD cycles.
REQ-021 Pop and push on the same edge SHALL both take effect; fifo_count unchanged; full FIFO frees one slot the cycle after a pop.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by count, count never exceeds FIFO_DEPTH.
REQ-023 busy SHALL be high whenever state != IDLE or fifo_count != 0.

Reset
REQ-024 On rst: state=IDLE, serial_out=1, baud counter=0, bit index=0, FIFO emptied (fifo_count=0), data_in_ready=1 the following cycle, busy=0; reset mid-frame aborts the frame with no further line toggles; push in a reset cycle is discarded.

Configuration
REQ-025 With UART_TX_PARITY_EN defined: PARITY state after DATA drives the even-parity bit (XOR of 8 data bits) for one baud period, frame = 11 bits; without it: PARITY state absent, frame = 10 bits, DATA goes directly to STOP.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state typedef, the CLOCKS_PER_BAUD computation function and the UART_FRAME_BITS constant (10 or 11, tracking UART_TX_PARITY_EN).
REQ-027 FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count); the serializer FSM lives in uart_tx_buffered.

Verification (defaults: 5 clk/bit, 50 clk/frame)
REQ-028 Single byte 0xA5 pushed at cycle 0 -> line low cycles 2-6, then bits 1,0,1,0,0,1,0,1 at 5 cycles each, high stop cycles 47-51, busy falls after stop.
REQ-029 Burst of 8 bytes 0x00..0x07 with valid held high -> all accepted, data_in_ready low when fifo_count=8, frames back-to-back with no idle gap, bench UART receiver decodes 0x00..0x07 in order.
REQ-030 Push attempt with FIFO full (fifo_count=8) -> byte not stored, fifo_count stays 8, next decoded sequence excludes it.
REQ-031 Push concurrent with STOP-end pop at fifo_count=3 -> fifo_count remains 3 after that edge.
REQ-032 Assert rst at cycle 20 of a frame of 0x3C with 2 bytes queued -> serial_out=1 next cycle and stays high, fifo_count=0, busy=0, no byte decoded.
REQ-033 With UART_TX_PARITY_EN, byte 0x07 -> parity bit 1 after bit 7, frame 55 cycles; byte 0x03 -> parity bit 0.
